// File: rtl/sd4_align_array.sv
// SD4 MAC partial-product aligner: per-lane shift to the max exponent,
// optional round-half-up, two's-complement output, 2-stage valid/ready pipe.
module sd4_align_array #(
    parameter int LANES = 4,
    parameter int EXP_W = 5,
    parameter int MAG_W = 4,
    parameter int OUT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         lane_en,
    input  logic [LANES*EXP_W-1:0]   exp,
    input  logic [LANES*(MAG_W+1)-1:0] signed_pp,
    input  logic                     round_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W-1:0]         exp_max,
    output logic [LANES*OUT_W-1:0]   aligned_pp
);
    localparam int PP_W = MAG_W + 1;
    localparam int SH_W = OUT_W - 1;

    logic                     s1_valid_q;
    logic [LANES-1:0]         s1_en_q;
    logic [LANES*EXP_W-1:0]   s1_exp_q;
    logic [LANES*PP_W-1:0]    s1_pp_q;
    logic                     s1_rnd_q;
    logic [EXP_W-1:0]         s1_emax_q;
    logic                     s2_valid_q;
    logic [EXP_W-1:0]         s2_emax_q;
    logic [LANES*OUT_W-1:0]   s2_pp_q;

    logic                     s1_adv;
    logic                     s2_adv;
    logic [EXP_W-1:0]         emax_d;
    logic [LANES*OUT_W-1:0]   aligned_d;

    // Guard is the last bit shifted out; it is added back when rounding.
    function automatic logic [OUT_W-1:0] align_lane(
        input logic [EXP_W-1:0] emax,
        input logic [EXP_W-1:0] e,
        input logic [PP_W-1:0]  pp,
        input logic             rnd
    );
        logic [EXP_W-1:0] diff;
        logic [31:0]      d;
        logic [SH_W-1:0]  base;
        logic [SH_W-1:0]  sh;
        logic [SH_W-1:0]  lost;
        logic             guard;
        logic [OUT_W-1:0] mag;
        diff = emax - e;
        d    = 32'(diff);
        base = {pp[MAG_W-1:0], {(SH_W-MAG_W){1'b0}}};
        lost = '0;
        if (d >= SH_W) begin
            sh    = '0;
            guard = (d == SH_W) ? pp[MAG_W-1] : 1'b0;
        end else begin
            sh    = base >> d;
            if (d != 0) lost = base >> (d - 1);
            guard = (d != 0) ? lost[0] : 1'b0;
        end
        if (rnd) sh = sh + SH_W'(guard);
        mag = {1'b0, sh};
        return pp[MAG_W] ? -mag : mag;
    endfunction

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign exp_max   = s2_emax_q;
    assign aligned_pp = s2_pp_q;

    always_comb begin
        emax_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i] && exp[i*EXP_W +: EXP_W] > emax_d)
                emax_d = exp[i*EXP_W +: EXP_W];
        end
    end

    always_comb begin
        aligned_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_en_q[i])
                aligned_d[i*OUT_W +: OUT_W] = align_lane(
                    s1_emax_q, s1_exp_q[i*EXP_W +: EXP_W],
                    s1_pp_q[i*PP_W +: PP_W], s1_rnd_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_en_q    <= '0;
            s1_exp_q   <= '0;
            s1_pp_q    <= '0;
            s1_rnd_q   <= 1'b0;
            s1_emax_q  <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_en_q   <= lane_en;
                s1_exp_q  <= exp;
                s1_pp_q   <= signed_pp;
                s1_rnd_q  <= round_mode;
                s1_emax_q <= emax_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_emax_q  <= '0;
            s2_pp_q    <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_emax_q <= s1_emax_q;
                s2_pp_q   <= aligned_d;
            end
        end
    end
endmodule

// File: tb/tb_sd4_align_array.sv
// Bench for sd4_align_array: directed spec vectors plus randomized
// streams scored against an integer-arithmetic reference model.
module tb_sd4_align_array;
    localparam int LANES = 4;
    localparam int EXP_W = 5;
    localparam int MAG_W = 4;
    localparam int OUT_W = 16;
    localparam int PP_W  = MAG_W + 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES-1:0]         lane_en;
    logic [LANES*EXP_W-1:0]   exp;
    logic [LANES*PP_W-1:0]    signed_pp;
    logic                     round_mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [EXP_W-1:0]         exp_max;
    logic [LANES*OUT_W-1:0]   aligned_pp;

    int checks = 0;
    int failures = 0;

    logic [EXP_W-1:0]       q_exp[$];
    logic [LANES*OUT_W-1:0] q_pp[$];

    sd4_align_array #(.LANES(LANES), .EXP_W(EXP_W), .MAG_W(MAG_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .lane_en(lane_en), .exp(exp), .signed_pp(signed_pp),
        .round_mode(round_mode), .out_valid(out_valid), .out_ready(out_ready),
        .exp_max(exp_max), .aligned_pp(aligned_pp)
    );

    always #5 clk = ~clk;

    function automatic logic [LANES*EXP_W-1:0] pk_exp(int e0, int e1, int e2, int e3);
        return {5'(e3), 5'(e2), 5'(e1), 5'(e0)};
    endfunction

    function automatic logic [LANES*PP_W-1:0] pk_pp(logic [4:0] a, logic [4:0] b,
                                                     logic [4:0] c, logic [4:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [EXP_W-1:0] m_emax(logic [LANES-1:0] en,
                                                logic [LANES*EXP_W-1:0] ev);
        int m;
        m = 0;
        for (int i = 0; i < LANES; i++)
            if (en[i] && int'(ev[i*EXP_W +: EXP_W]) > m) m = int'(ev[i*EXP_W +: EXP_W]);
        return EXP_W'(m);
    endfunction

    // Value = mag * 2^(OUT_W-1-MAG_W) / 2^diff, floored or rounded half up.
    function automatic logic [LANES*OUT_W-1:0] m_bundle(logic [LANES-1:0] en,
            logic [LANES*EXP_W-1:0] ev, logic [LANES*PP_W-1:0] pv, logic rnd);
        logic [LANES*OUT_W-1:0] r;
        longint base, v, scale;
        int d, emax;
        logic [PP_W-1:0] pp;
        r = '0;
        emax = int'(m_emax(en, ev));
        for (int i = 0; i < LANES; i++) begin
            if (en[i]) begin
                pp = pv[i*PP_W +: PP_W];
                d = emax - int'(ev[i*EXP_W +: EXP_W]);
                base = longint'(pp[MAG_W-1:0]) * (longint'(1) << (OUT_W-1-MAG_W));
                scale = longint'(1) << d;
                if (rnd && d > 0) v = (base + scale / 2) / scale;
                else v = base / scale;
                if (pp[MAG_W]) v = -v;
                r[i*OUT_W +: OUT_W] = OUT_W'(v);
            end
        end
        return r;
    endfunction

    task automatic rand_inputs();
        lane_en    = LANES'($urandom);
        exp        = (LANES*EXP_W)'($urandom);
        signed_pp  = (LANES*PP_W)'($urandom);
        round_mode = 1'($urandom);
    endtask

    // Drives one bundle on an idle pipe; returns outputs and latency (-1 on timeout).
    task automatic run_one(input logic [LANES-1:0] en, input logic [LANES*EXP_W-1:0] ev,
            input logic [LANES*PP_W-1:0] pv, input logic rnd,
            output logic [EXP_W-1:0] ge, output logic [LANES*OUT_W-1:0] gp, output int lat);
        int n;
        @(negedge clk);
        lane_en = en; exp = ev; signed_pp = pv; round_mode = rnd;
        in_valid = 1'b1; out_ready = 1'b1;
        lat = -1; ge = '0; gp = '0;
        n = 0;
        while (!in_ready && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        rand_inputs();
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (out_valid) begin ge = exp_max; gp = aligned_pp; lat = c; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        rand_inputs();
        lane_en = '1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (aligned_pp !== '0 || exp_max !== '0) begin failures++;
            $display("FAIL reset_data got=%h/%h exp=0/0", aligned_pp, exp_max); end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++;
            $display("FAIL reset_no_ghost got=%b exp=0", out_valid); end
    endtask

    task automatic test_align();
        logic [EXP_W-1:0] ge; logic [LANES*OUT_W-1:0] gp, ev; int lat;
        logic [LANES*EXP_W-1:0] e; logic [LANES*PP_W-1:0] p;
        e = pk_exp(10, 8, 10, 3);
        p = pk_pp(5'b01011, 5'b01011, 5'b01011, 5'b01011);
        run_one(4'hF, e, p, 1'b0, ge, gp, lat);
        ev = {16'h00B0, 16'h5800, 16'h1600, 16'h5800};
        checks++;
        if (lat != 2) begin failures++; $display("FAIL align_latency got=%0d exp=2", lat); end
        checks++;
        if (ge !== 5'd10) begin failures++; $display("FAIL align_emax got=%0d exp=10", ge); end
        checks++;
        if (gp !== ev) begin failures++; $display("FAIL align_lanes got=%h exp=%h", gp, ev); end
        checks++;
        if (gp !== m_bundle(4'hF, e, p, 1'b0)) begin failures++;
            $display("FAIL align_model got=%h exp=%h", gp, m_bundle(4'hF, e, p, 1'b0)); end
    endtask

    task automatic test_sign_zero();
        logic [EXP_W-1:0] ge; logic [LANES*OUT_W-1:0] gp, ev; int lat;
        run_one(4'b0111, pk_exp(20, 20, 3, 25),
                pk_pp(5'b11011, 5'b10000, 5'b01111, 5'b01111), 1'b1, ge, gp, lat);
        ev = {16'h0000, 16'h0000, 16'h0000, 16'hA800};
        checks++;
        if (lat != 2 || ge !== 5'd20) begin failures++;
            $display("FAIL sign_emax got=%0d lat=%0d exp=20 lat=2", ge, lat); end
        checks++;
        if (gp !== ev) begin failures++; $display("FAIL sign_zero got=%h exp=%h", gp, ev); end
    endtask

    task automatic test_rounding();
        logic [EXP_W-1:0] ge; logic [LANES*OUT_W-1:0] gp, ev; int lat;
        logic [LANES*EXP_W-1:0] e; logic [LANES*PP_W-1:0] p;
        e = pk_exp(20, 8, 8, 5);
        p = pk_pp(5'b01011, 5'b01011, 5'b11011, 5'b01000);
        run_one(4'hF, e, p, 1'b0, ge, gp, lat);
        checks++;
        if (gp[31:16] !== 16'h0005 || gp[47:32] !== 16'hFFFB) begin failures++;
            $display("FAIL round_trunc got=%h/%h exp=0005/fffb", gp[31:16], gp[47:32]); end
        run_one(4'hF, e, p, 1'b1, ge, gp, lat);
        checks++;
        if (gp[31:16] !== 16'h0006 || gp[47:32] !== 16'hFFFA) begin failures++;
            $display("FAIL round_half_up got=%h/%h exp=0006/fffa", gp[31:16], gp[47:32]); end
        checks++;
        if (gp !== m_bundle(4'hF, e, p, 1'b1)) begin failures++;
            $display("FAIL round_model got=%h exp=%h", gp, m_bundle(4'hF, e, p, 1'b1)); end
    endtask

    task automatic test_lane_en();
        logic [EXP_W-1:0] ge; logic [LANES*OUT_W-1:0] gp, ev; int lat;
        logic [LANES*PP_W-1:0] p;
        p = pk_pp(5'b01011, 5'b01011, 5'b01011, 5'b01011);
        run_one(4'b0010, pk_exp(31, 4, 31, 31), p, 1'b0, ge, gp, lat);
        ev = {16'h0000, 16'h0000, 16'h5800, 16'h0000};
        checks++;
        if (ge !== 5'd4 || gp !== ev) begin failures++;
            $display("FAIL lane_en_one got=%0d/%h exp=4/%h", ge, gp, ev); end
        run_one(4'b0000, pk_exp(31, 4, 31, 31), p, 1'b1, ge, gp, lat);
        checks++;
        if (lat != 2 || ge !== '0 || gp !== '0) begin failures++;
            $display("FAIL lane_en_none got=%0d/%h lat=%0d exp=0/0 lat=2", ge, gp, lat); end
    endtask

    task automatic test_back_to_back();
        int sent, rcvd;
        localparam int N = 10;
        sent = 0; rcvd = 0;
        q_exp.delete(); q_pp.delete();
        @(negedge clk);
        out_ready = 1'b1;
        for (int c = 0; c < N + 2; c++) begin
            in_valid = (sent < N);
            rand_inputs();
            #1;
            if (in_valid) begin
                checks++;
                if (in_ready !== 1'b1) begin failures++;
                    $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", c, in_ready); end
            end
            if (out_valid) begin
                checks++;
                if (q_pp.size() == 0) begin failures++;
                    $display("FAIL b2b_extra got=%h exp=none", aligned_pp); end
                else begin
                    if (exp_max !== q_exp[0] || aligned_pp !== q_pp[0]) begin failures++;
                        $display("FAIL b2b_data got=%h/%h exp=%h/%h",
                                 exp_max, aligned_pp, q_exp[0], q_pp[0]); end
                    void'(q_exp.pop_front()); void'(q_pp.pop_front()); rcvd++;
                end
            end
            if (in_valid && in_ready) begin
                q_exp.push_back(m_emax(lane_en, exp));
                q_pp.push_back(m_bundle(lane_en, exp, signed_pp, round_mode));
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (rcvd != N) begin failures++;
            $display("FAIL b2b_rate got=%0d exp=%0d bundles in %0d cycles", rcvd, N, N + 2); end
    endtask

    task automatic test_backpressure();
        localparam int N = 40;
        bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int sent, rcvd, cyc, occ;
        bit stalled, exp_rdy;
        logic [EXP_W-1:0] h_e;
        logic [LANES*OUT_W-1:0] h_p;
        sent = 0; rcvd = 0; cyc = 0; occ = 0; stalled = 0;
        h_e = '0; h_p = '0;
        q_exp.delete(); q_pp.delete();
        @(negedge clk);
        while (rcvd < N && cyc < 600) begin
            out_ready = (cyc < 30) ? pat[cyc % 6] : 1'($urandom);
            in_valid = (sent < N) && ($urandom_range(3) != 0);
            rand_inputs();
            #1;
            exp_rdy = !(occ == 2 && !out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin failures++;
                $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || exp_max !== h_e || aligned_pp !== h_p) begin
                    failures++;
                    $display("FAIL bp_stable cyc=%0d got=%b/%h exp=1/%h",
                             cyc, out_valid, aligned_pp, h_p);
                end
            end
            if (out_valid) begin
                checks++;
                if (q_pp.size() == 0) begin failures++;
                    $display("FAIL bp_dup cyc=%0d got=%h exp=none", cyc, aligned_pp); end
                else if (exp_max !== q_exp[0] || aligned_pp !== q_pp[0]) begin failures++;
                    $display("FAIL bp_data cyc=%0d got=%h/%h exp=%h/%h",
                             cyc, exp_max, aligned_pp, q_exp[0], q_pp[0]);
                end
            end
            stalled = out_valid && !out_ready;
            h_e = exp_max; h_p = aligned_pp;
            if (out_valid && out_ready && q_pp.size() != 0) begin
                void'(q_exp.pop_front()); void'(q_pp.pop_front());
                rcvd++; occ--;
            end
            if (in_valid && in_ready) begin
                q_exp.push_back(m_emax(lane_en, exp));
                q_pp.push_back(m_bundle(lane_en, exp, signed_pp, round_mode));
                sent++; occ++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (rcvd != N) begin failures++;
            $display("FAIL bp_count got=%0d exp=%0d (cycle budget)", rcvd, N); end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++;
            $display("FAIL bp_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_inputs();
        @(negedge clk);
        rand_inputs();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++;
            $display("FAIL midrst_full got=%b/%b exp=1/0", out_valid, in_ready); end
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || aligned_pp !== '0 || exp_max !== '0
            || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_flush got=%b/%h/%h/%b exp=0/0/0/1",
                     out_valid, aligned_pp, exp_max, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++;
            $display("FAIL midrst_no_output got=%b exp=0", out_valid); end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        lane_en = '0; exp = '0; signed_pp = '0; round_mode = 1'b0;
        test_reset();
        test_align();
        test_sign_zero();
        test_rounding();
        test_lane_en();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
